// File: rtl/sram_obi_wrapper.sv
// sram_obi_wrapper: single-port behavioural RAM behind an OBI-style
// req/gnt/rvalid handshake. It has per-byte write enables and a built-in
// engine that clears the array after every reset.
// Optional define SRAM_OBI_OUT_REG_EN adds an output register stage, which
// makes the response latency 2 cycles.
module sram_obi_wrapper #(
  parameter int unsigned            NumWords  = 1024,
  parameter int unsigned            DataWidth = 32,
  parameter logic [DataWidth-1:0]   InitValue = '0,
  localparam int unsigned           AddrWidth = $clog2(NumWords),
  localparam int unsigned           BeWidth   = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 init_done_o
);

  typedef enum logic {
    StInit  = 1'b0,
    StReady = 1'b1
  } state_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  state_e               state_q;
  logic [AddrWidth-1:0] cnt_q;
  logic                 init_done_q;
  logic [DataWidth-1:0] mem_q [NumWords];
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;

  logic                 accept;
  logic                 in_range;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_waddr;
  logic [DataWidth-1:0] mem_wdata;
  logic [BeWidth-1:0]   mem_wbe;

  // Requests are granted only once the clear has finished.
  assign gnt_o       = (state_q == StReady);
  assign init_done_o = init_done_q;
  assign accept      = req_i & gnt_o;
  assign in_range    = (32'(addr_i) < NumWords);

  // Single write port, shared between the init engine and bus writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = InitValue;
    mem_wbe   = '1;
    if (!rst_i) begin
      if (state_q == StInit) begin
        mem_we = 1'b1;
      end else if (accept && we_i && in_range) begin
        mem_we    = 1'b1;
        mem_waddr = addr_i;
        mem_wdata = wdata_i;
        mem_wbe   = be_i;
      end
    end
  end

  // Byte-masked array write; the array has no reset because the init engine clears it.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BeWidth; b++) begin
        if (mem_wbe[b]) begin
          mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Init/ready FSM. The counter stops at the last word and never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          if (cnt_q == LastAddr) begin
            state_q     <= StReady;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AddrWidth'(1);
          end
        end
        StReady: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

  // First response stage. Every accept gives one rvalid; only reads load rdata.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= accept;
      if (accept && !we_i) begin
        rdata_q <= in_range ? mem_q[addr_i] : '0;
      end
    end
  end

`ifdef SRAM_OBI_OUT_REG_EN
  logic                 rvalid_s_q;
  logic [DataWidth-1:0] rdata_s_q;

  // Extra output stage; rdata only advances with a valid response so it holds between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_s_q <= 1'b0;
      rdata_s_q  <= '0;
    end else begin
      rvalid_s_q <= rvalid_q;
      if (rvalid_q) begin
        rdata_s_q <= rdata_q;
      end
    end
  end

  assign rvalid_o = rvalid_s_q;
  assign rdata_o  = rdata_s_q;
`else
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
`endif

endmodule

// File: tb/tb_sram_obi_wrapper.sv
// Directed bench for sram_obi_wrapper.
// It uses a 16-word instance and a 12-word instance (out-of-range addresses).
module tb_sram_obi_wrapper;

`ifdef SRAM_OBI_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req16 = 1'b0, we16 = 1'b0, gnt16, rvalid16, done16;
  logic [3:0]  addr16 = '0, be16 = '0;
  logic [31:0] wdata16 = '0, rdata16;

  logic        req12 = 1'b0, we12 = 1'b0, gnt12, rvalid12, done12;
  logic [3:0]  addr12 = '0, be12 = '0;
  logic [31:0] wdata12 = '0, rdata12;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] r16_d[$];
  int          r16_c[$];
  logic [31:0] r12_d[$];

  sram_obi_wrapper #(.NumWords(16), .DataWidth(32), .InitValue(32'hDEAD_BEEF)) dut16 (
    .clk_i(clk), .rst_i(rst), .req_i(req16), .gnt_o(gnt16), .we_i(we16),
    .addr_i(addr16), .wdata_i(wdata16), .be_i(be16), .rvalid_o(rvalid16),
    .rdata_o(rdata16), .init_done_o(done16)
  );

  sram_obi_wrapper #(.NumWords(12), .DataWidth(32), .InitValue(32'h5A5A_5A5A)) dut12 (
    .clk_i(clk), .rst_i(rst), .req_i(req12), .gnt_o(gnt12), .we_i(we12),
    .addr_i(addr12), .wdata_i(wdata12), .be_i(be12), .rvalid_o(rvalid12),
    .rdata_o(rdata12), .init_done_o(done12)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (rvalid16 === 1'b1) begin
      r16_d.push_back(rdata16);
      r16_c.push_back(cyc);
    end
    if (rvalid12 === 1'b1) r12_d.push_back(rdata12);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue16(input logic w, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] b, output int acc);
    req16 = 1'b1; we16 = w; addr16 = a; wdata16 = d; be16 = b;
    tick();
    acc = cyc;
  endtask

  task automatic issue12(input logic w, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] b);
    req12 = 1'b1; we12 = w; addr12 = a; wdata12 = d; be12 = b;
    tick();
  endtask

  task automatic drain();
    req16 = 1'b0;
    req12 = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  task automatic clear_q();
    r16_d.delete();
    r16_c.delete();
    r12_d.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (gnt16 !== 1'b0) begin failures++; $display("FAIL rst_gnt got %b exp 0", gnt16); end
    checks++; if (rvalid16 !== 1'b0) begin failures++; $display("FAIL rst_rvalid got %b exp 0", rvalid16); end
    checks++; if (done16 !== 1'b0) begin failures++; $display("FAIL rst_done got %b exp 0", done16); end
    checks++; if (rdata16 !== 32'h0) begin failures++; $display("FAIL rst_rdata got %h exp 0", rdata16); end
    rst = 1'b0;
    repeat (15) tick();
    checks++; if (gnt16 !== 1'b0 || done16 !== 1'b0) begin
      failures++; $display("FAIL init_early gnt=%b done=%b exp 0 0 after 15 cycles", gnt16, done16);
    end
    tick();
    checks++; if (gnt16 !== 1'b1 || done16 !== 1'b1) begin
      failures++; $display("FAIL init_16 gnt=%b done=%b exp 1 1 after 16 cycles", gnt16, done16);
    end
  endtask

  task automatic test_init_value();
    int acc;
    clear_q();
    for (int a = 0; a < 16; a++) issue16(1'b0, 4'(a), 32'h0, 4'h0, acc);
    drain();
    checks++; if (r16_d.size() !== 16) begin failures++; $display("FAIL init_cnt got %0d exp 16", r16_d.size()); end
    if (r16_d.size() == 16) begin
      for (int a = 0; a < 16; a++) begin
        checks++; if (r16_d[a] !== 32'hDEAD_BEEF) begin
          failures++; $display("FAIL init_val addr %0d got %h exp deadbeef", a, r16_d[a]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    int a0, a1;
    clear_q();
    issue16(1'b1, 4'd5, 32'h1234_5678, 4'hF, a0);
    issue16(1'b0, 4'd5, 32'h0, 4'h0, a1);
    drain();
    checks++; if (r16_d.size() !== 2) begin failures++; $display("FAIL wr_cnt got %0d exp 2", r16_d.size()); end
    if (r16_d.size() == 2) begin
      checks++; if (r16_c[0] !== a0 + LAT - 1) begin failures++; $display("FAIL wr_lat got %0d exp %0d", r16_c[0], a0 + LAT - 1); end
      checks++; if (r16_c[1] !== a1 + LAT - 1) begin failures++; $display("FAIL rd_lat got %0d exp %0d", r16_c[1], a1 + LAT - 1); end
      checks++; if (r16_d[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_hold got %h exp deadbeef", r16_d[0]); end
      checks++; if (r16_d[1] !== 32'h1234_5678) begin failures++; $display("FAIL rd_new got %h exp 12345678", r16_d[1]); end
    end
  endtask

  task automatic test_byte_enable();
    int acc;
    logic [31:0] exp_d [5];
    exp_d[0] = 32'h1234_5678; exp_d[1] = 32'h1234_5678; exp_d[2] = 32'hAA22_CC44;
    exp_d[3] = 32'hAA22_CC44; exp_d[4] = 32'hAA22_CC44;
    clear_q();
    issue16(1'b1, 4'd3, 32'hAABB_CCDD, 4'hF, acc);
    issue16(1'b1, 4'd3, 32'h1122_3344, 4'b0101, acc);
    issue16(1'b0, 4'd3, 32'h0, 4'h0, acc);
    issue16(1'b1, 4'd3, 32'hFFFF_FFFF, 4'h0, acc);
    issue16(1'b0, 4'd3, 32'h0, 4'h0, acc);
    drain();
    checks++; if (r16_d.size() !== 5) begin failures++; $display("FAIL be_cnt got %0d exp 5", r16_d.size()); end
    if (r16_d.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (r16_d[i] !== exp_d[i]) begin
          failures++; $display("FAIL be_data resp %0d got %h exp %h", i, r16_d[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, first;
    first = 0;
    for (int i = 0; i < 10; i++) issue16(1'b1, 4'(i), 32'hC0DE_0000 + 32'(i), 4'hF, acc);
    drain();
    clear_q();
    for (int i = 0; i < 10; i++) begin
      issue16(1'b0, 4'(i), 32'h0, 4'h0, acc);
      if (i == 0) first = acc;
    end
    drain();
    checks++; if (r16_d.size() !== 10) begin failures++; $display("FAIL b2b_cnt got %0d exp 10", r16_d.size()); end
    if (r16_d.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        checks++; if (r16_d[i] !== 32'hC0DE_0000 + 32'(i) || r16_c[i] !== first + i + LAT - 1) begin
          failures++;
          $display("FAIL b2b resp %0d got %h@%0d exp %h@%0d", i, r16_d[i], r16_c[i],
                   32'hC0DE_0000 + 32'(i), first + i + LAT - 1);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h0; exp_d[1] = 32'h0; exp_d[2] = 32'h5A5A_5A5A; exp_d[3] = 32'h5A5A_5A5A;
    clear_q();
    issue12(1'b1, 4'd13, 32'hFFFF_FFFF, 4'hF);
    issue12(1'b0, 4'd13, 32'h0, 4'h0);
    issue12(1'b0, 4'd1, 32'h0, 4'h0);
    issue12(1'b0, 4'd11, 32'h0, 4'h0);
    drain();
    checks++; if (r12_d.size() !== 4) begin failures++; $display("FAIL oor_cnt got %0d exp 4", r12_d.size()); end
    if (r12_d.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (r12_d[i] !== exp_d[i]) begin
          failures++; $display("FAIL oor_data resp %0d got %h exp %h", i, r12_d[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_init_reset();
    int acc;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (7) tick();
    checks++; if (done16 !== 1'b0) begin failures++; $display("FAIL mid_init_done got %b exp 0", done16); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_q();
    req16 = 1'b1; we16 = 1'b0; addr16 = 4'd5;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++; if (gnt16 !== 1'b0 || done16 !== 1'b0) begin
        failures++; $display("FAIL reinit_busy cycle %0d gnt=%b done=%b exp 0 0", i, gnt16, done16);
      end
    end
    tick();
    req16 = 1'b0;
    checks++; if (gnt16 !== 1'b1 || done16 !== 1'b1) begin
      failures++; $display("FAIL reinit_16 gnt=%b done=%b exp 1 1", gnt16, done16);
    end
    drain();
    checks++; if (r16_d.size() !== 0) begin failures++; $display("FAIL init_req_resp got %0d exp 0", r16_d.size()); end
    clear_q();
    issue16(1'b0, 4'd5, 32'h0, 4'h0, acc);
    issue16(1'b0, 4'd3, 32'h0, 4'h0, acc);
    drain();
    checks++; if (r16_d.size() !== 2) begin failures++; $display("FAIL reclr_cnt got %0d exp 2", r16_d.size()); end
    if (r16_d.size() == 2) begin
      checks++; if (r16_d[0] !== 32'hDEAD_BEEF || r16_d[1] !== 32'hDEAD_BEEF) begin
        failures++; $display("FAIL reclr_data got %h %h exp deadbeef deadbeef", r16_d[0], r16_d[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_value();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_init_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_obi_wrapper.md
Name: sram_obi_wrapper

Overview:
Parametrised single-port on-chip RAM with an OBI-style req/gnt/rvalid handshake, generic data width and depth, and per-byte write enables. After every reset, a built-in init engine clears the whole array to a programmable value before granting any request. It sits between the accelerator's bus adapter and the memory array, and is implemented as an inferable behavioural array, not a vendor IP instance.

Parameters:
NumWords, 1024, number of words in the array; any value >= 2.
DataWidth, 32, word width in bits; must be a multiple of 8.
InitValue, '0, DataWidth-bit value written to every word during init.
AddrWidth, $clog2(NumWords), derived; must not be overridden.
BeWidth, DataWidth/8, derived; must not be overridden.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
req_i  in  1  request valid.
gnt_o  out  1  request accepted this cycle if req_i is also high.
we_i  in  1  1 = write, 0 = read; sampled with req_i.
addr_i  in  AddrWidth  word address.
wdata_i  in  DataWidth  write data.
be_i  in  BeWidth  byte enables; bit k controls bits 8k+7:8k.
rvalid_o  out  1  response valid, one pulse per accepted request.
rdata_o  out  DataWidth  read data; valid when rvalid_o is high after a read.
init_done_o  out  1  high once init is complete; stays high until the next reset.

Behaviour:
- Reset (rst_i high at an edge): state goes to INIT, init counter goes to 0, and gnt_o, rvalid_o, init_done_o, and rdata_o all go to 0. Reset takes priority over everything else.
- FSM states: INIT and READY.
- INIT: each edge with rst_i low writes InitValue to mem[cnt], then cnt increments. On the edge that writes word NumWords-1, the state moves to READY. Init therefore takes exactly NumWords cycles.
- In INIT, gnt_o is 0 and req_i is ignored; no response is produced.
- READY: gnt_o is 1 (combinational from state); init_done_o is 1.
- Handshake: a request is accepted at an edge where req_i & gnt_o is high. There is no backpressure on responses.
- Response latency: 1 cycle. rvalid_o is high in the cycle after acceptance, for reads and writes alike. Back-to-back accepts give back-to-back rvalid_o pulses.
- Read: rdata_o is loaded with mem[addr_i] at the accept edge. A read immediately after a write to the same address returns the new data.
- Write: only bytes with be_i set are updated; other bytes are preserved. A write with be_i = 0 changes nothing but still produces rvalid_o.
- After a write, rdata_o holds its previous value.
- rdata_o holds its value when rvalid_o is low.
- Out-of-range address (addr_i >= NumWords, possible only when NumWords is not a power of two): writes are dropped; reads return all-zero. Both still produce rvalid_o.
- Reset mid-init: the counter restarts at 0 and the full clear re-runs.
- Reset while in READY: any pending rvalid_o is cancelled, the array is re-cleared, and gnt_o drops on the same edge.
- Width rule: the counter is AddrWidth bits wide, and its terminal compare is against NumWords-1, so there is no wrap-around past the array.

Optional Feature:
Macro SRAM_OBI_OUT_REG_EN.
- Defined: an extra output register stage is added. Read and write response latency becomes 2 cycles, and rvalid_o and rdata_o both pass through the stage. The design stays fully pipelined, with one response per cycle. Reset clears the stage.
- Undefined: latency is 1 cycle as described under Behaviour.

Test Plan:
- Reset, then release with NumWords=16, InitValue=32'hDEAD_BEEF -> gnt_o and init_done_o rise exactly 16 cycles after release; reading addresses 0..15 returns 32'hDEAD_BEEF.
- Write 32'h1234_5678 to addr 5 with be=4'hF, then read addr 5 on the next cycle -> rvalid_o pulses one cycle after each accept; the read returns 32'h1234_5678.
- Word at addr 3 = 32'hAABB_CCDD; write 32'h1122_3344 with be=4'b0101 -> a read returns 32'hAA22_CC44. A write with be=0 leaves it unchanged and still pulses rvalid_o.
- Ten back-to-back reads with req_i held high -> ten consecutive rvalid_o cycles in order, with no gaps.
- Assert rst_i at init cycle 7, then release -> init_done_o asserts a full NumWords cycles after release; req_i during init gets no gnt_o and no rvalid_o.
- NumWords=12: write addr 13, then read addr 13 -> rvalid_o is high and rdata_o=0. With SRAM_OBI_OUT_REG_EN defined, all checks above pass with 2-cycle latency.
